reg_file_sb16: RTL and testbench
================================

Name: reg_file_sb16

Overview:
- 16-entry x 16-bit general-purpose register file with 2 read ports, 1 write-back port and a per-register busy scoreboard.
- Sits in the decode stage, directly upstream of the operand-select multiplexing: its two read outputs are the register operand inputs of the operand-select muxes.
- The scoreboard tracks registers with an outstanding write and raises a stall when a decoded instruction depends on one.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, register address width.
- NREGS, 16, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ra_addr  input  ADDR_W  read port A address.
- ra_en  input  1  port A operand is used by the decoded instruction.
- rb_addr  input  ADDR_W  read port B address.
- rb_en  input  1  port B operand is used by the decoded instruction.
- ra_data  output  DATA_W  port A read data, combinational.
- rb_data  output  DATA_W  port B read data, combinational.
- iss_en  input  1  decoded instruction requests issue.
- iss_wr  input  1  issuing instruction writes a destination register.
- iss_addr  input  ADDR_W  destination register of the issuing instruction.
- wb_en  input  1  write-back valid.
- wb_addr  input  ADDR_W  write-back register.
- wb_data  input  DATA_W  write-back data.
- stall  output  1  issue blocked this cycle, combinational.
- busy_vec  output  NREGS  current scoreboard bits, registered.

Behaviour:
- Reset (reset=1 at a clk edge): all registers = 0 and busy_vec = 0. With addresses 0, ra_data = rb_data = 0 and stall = 0 the cycle after reset. Reset overrides any same-cycle wb_en or iss_en.
- Reset asserted mid-operation discards all pending busy bits. Write-backs still in flight after reset are written normally but clear nothing.
- Write: on clk edge with wb_en=1, reg[wb_addr] <= wb_data and busy[wb_addr] <= 0, unless the set rule below applies in the same cycle. All 16 registers are writable; R0 is not hardwired.
- Read: ra_data = reg[ra_addr] and rb_data = reg[rb_addr], asynchronous with zero latency. See the Optional Feature for the same-cycle write case.
- Effective busy:
  - busy_eff[x] = busy[x] & ~(wb_en & wb_addr==x) when the bypass is compiled in.
  - busy_eff[x] = busy[x] otherwise.
- Stall: stall = iss_en & ((ra_en & busy_eff[ra_addr]) | (rb_en & busy_eff[rb_addr]) | (iss_wr & busy_eff[iss_addr])).
  - The last term blocks WAW, giving at most one outstanding write per register.
  - stall = 0 whenever iss_en = 0.
- Issue accepted when iss_en & ~stall. If iss_wr is also set, busy[iss_addr] <= 1 on the edge.
- Simultaneous events:
  - Set and clear on the same register in the same edge (accepted issue to X, wb to X): busy[X] ends at 1. The new producer wins.
  - wb_en to a register that is not busy: data is written and busy stays 0 (legal, e.g. direct writes).
  - Stalled issue: no scoreboard change. The upstream stage holds its inputs and retries; no internal retry state exists.
- busy_vec is a direct register output, with no combinational path from inputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if wb_en & wb_addr==ra_addr, ra_data = wb_data (same for port B).
  - busy_eff masks the register being written back this cycle, so a dependent instruction issues in the same cycle as its producer's write-back.
- Undefined:
  - Reads return the stored value only.
  - busy_eff = busy, so a dependent instruction stalls through the write-back cycle and issues one cycle later.
- Stored-state behaviour is identical in both builds.

Test Plan:
- Reset check: after reset, read all 16 addresses -> every ra_data and rb_data = 16'h0000, busy_vec = 16'h0000, stall = 0.
- Write/read: wb_en=1, wb_addr=5, wb_data=16'hA5A5, then next cycle ra_addr=5, rb_addr=5 -> both read 16'hA5A5. busy_vec[5] stays 0.
- RAW stall:
  - Issue iss_wr=1, iss_addr=3 -> busy_vec = 16'h0008.
  - Next issue with ra_en=1, ra_addr=3 -> stall=1, held until write-back of R3.
  - Write-back of R3 = 16'h1234: with REGFILE_BYPASS_EN, stall drops in the write-back cycle and ra_data = 16'h1234. Without it, stall drops one cycle later.
- WAW and set/clear collision:
  - Busy R7, then issue with iss_addr=7 -> stall=1.
  - Issue to R7 in the same cycle as wb to R7 (bypass build) -> accepted; busy_vec[7] remains 1 after the edge.
- Unused operand: busy R9, issue with ra_addr=9, ra_en=0, iss_wr=0 -> stall=0; busy_vec unchanged.
- Reset mid-operation:
  - Set busy on R2, R4, R15 (busy_vec = 16'h8014), assert reset with a simultaneous wb to R4 -> busy_vec = 0 and R4 = 0.
  - A subsequent wb to R2 writes data and leaves busy_vec = 0.

Source files
------------

// File: rtl/reg_file_sb16_if.sv
// Decode-stage bus of reg_file_sb16: operand reads, issue request, write-back and scoreboard view.
interface reg_file_sb16_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NREGS  = 16
);
    logic [ADDR_W-1:0] ra_addr;
    logic              ra_en;
    logic [ADDR_W-1:0] rb_addr;
    logic              rb_en;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              iss_en;
    logic              iss_wr;
    logic [ADDR_W-1:0] iss_addr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic [NREGS-1:0]  busy_vec;

    modport master (
        output ra_addr, ra_en, rb_addr, rb_en,
        output iss_en, iss_wr, iss_addr,
        output wb_en, wb_addr, wb_data,
        input  ra_data, rb_data, stall, busy_vec
    );

    modport slave (
        input  ra_addr, ra_en, rb_addr, rb_en,
        input  iss_en, iss_wr, iss_addr,
        input  wb_en, wb_addr, wb_data,
        output ra_data, rb_data, stall, busy_vec
    );
endinterface

// File: rtl/reg_file_sb16.sv
// 16x16 register file, 2 read / 1 write-back port, with a per-register busy scoreboard.
// Optional build macro REGFILE_BYPASS_EN adds write-to-read forwarding and same-cycle wake-up.
module reg_file_sb16 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NREGS  = 16
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb16_if.slave bus
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [NREGS-1:0]  busy_eff;
    logic              stall_int;
    logic              issue_ok;

`ifdef REGFILE_BYPASS_EN
    logic [NREGS-1:0] wb_hit;

    always_comb begin
        wb_hit = '0;
        if (bus.wb_en) wb_hit[bus.wb_addr] = 1'b1;
    end

    // A register being written back this cycle no longer blocks its consumers.
    assign busy_eff = busy & ~wb_hit;

    always_comb begin
        bus.ra_data = regs[bus.ra_addr];
        bus.rb_data = regs[bus.rb_addr];
        if (bus.wb_en && (bus.wb_addr == bus.ra_addr)) bus.ra_data = bus.wb_data;
        if (bus.wb_en && (bus.wb_addr == bus.rb_addr)) bus.rb_data = bus.wb_data;
    end
`else
    assign busy_eff = busy;

    always_comb begin
        bus.ra_data = regs[bus.ra_addr];
        bus.rb_data = regs[bus.rb_addr];
    end
`endif

    // RAW on either used operand, or WAW on the destination, blocks issue.
    assign stall_int = bus.iss_en &
                       ((bus.ra_en  & busy_eff[bus.ra_addr]) |
                        (bus.rb_en  & busy_eff[bus.rb_addr]) |
                        (bus.iss_wr & busy_eff[bus.iss_addr]));
    assign issue_ok  = bus.iss_en & ~stall_int;

    // Set is applied after clear so a new producer wins over a same-cycle write-back.
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_en) busy_nxt[bus.wb_addr] = 1'b0;
        if (issue_ok && bus.iss_wr) busy_nxt[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (bus.wb_en) regs[bus.wb_addr] <= bus.wb_data;
            busy <= busy_nxt;
        end
    end

    assign bus.stall    = stall_int;
    assign bus.busy_vec = busy;

endmodule

// File: tb/tb_reg_file_sb16.sv
// Self-checking bench for reg_file_sb16: array/bitmask model compared every cycle plus directed literals.
module tb_reg_file_sb16;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reg_file_sb16_if #(.DATA_W(16), .ADDR_W(4), .NREGS(16)) bus ();

    reg_file_sb16 #(.DATA_W(16), .ADDR_W(4), .NREGS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [15:0] m_regs [16];
    bit          m_busy [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit blocked(input logic [3:0] a);
        blocked = m_busy[a] && !(BYP && bus.wb_en && bus.wb_addr == a);
    endfunction

    function automatic bit exp_stall();
        exp_stall = bus.iss_en && ((bus.ra_en && blocked(bus.ra_addr)) ||
                                   (bus.rb_en && blocked(bus.rb_addr)) ||
                                   (bus.iss_wr && blocked(bus.iss_addr)));
    endfunction

    function automatic logic [15:0] exp_read(input logic [3:0] a);
        if (BYP && bus.wb_en && bus.wb_addr == a) exp_read = bus.wb_data;
        else exp_read = m_regs[a];
    endfunction

    function automatic logic [15:0] busy_word();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = m_busy[i];
        busy_word = w;
    endfunction

    // Model update: reset wipes everything; otherwise write-back clears, accepted issue sets.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[i] = 16'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            bit acc;
            acc = bus.iss_en && !exp_stall();
            if (bus.wb_en) begin
                m_regs[bus.wb_addr] = bus.wb_data;
                m_busy[bus.wb_addr] = 1'b0;
            end
            if (acc && bus.iss_wr) m_busy[bus.iss_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ra_data", 32'(bus.ra_data), 32'(exp_read(bus.ra_addr)));
            chk("model_rb_data", 32'(bus.rb_data), 32'(exp_read(bus.rb_addr)));
            chk("model_stall", 32'(bus.stall), 32'(exp_stall()));
            chk("model_busy_vec", 32'(bus.busy_vec), 32'(busy_word()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ra_addr = 4'd0; bus.ra_en = 1'b0;
        bus.rb_addr = 4'd0; bus.rb_en = 1'b0;
        bus.iss_en = 1'b0; bus.iss_wr = 1'b0; bus.iss_addr = 4'd0;
        bus.wb_en = 1'b0; bus.wb_addr = 4'd0; bus.wb_data = 16'h0;
    endtask

    task automatic issue_wr(input logic [3:0] a);
        idle();
        bus.iss_en = 1'b1; bus.iss_wr = 1'b1; bus.iss_addr = a;
        tick();
    endtask

    task automatic wb(input logic [3:0] a, input logic [15:0] d);
        idle();
        bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 16'h0;
            m_busy[i] = 1'b0;
        end
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state across all addresses
        for (int i = 0; i < 16; i++) begin
            bus.ra_addr = 4'(i);
            bus.rb_addr = 4'(15 - i);
            @(negedge clk);
            chk("rst_ra", 32'(bus.ra_data), 32'h0);
            chk("rst_rb", 32'(bus.rb_data), 32'h0);
            chk("rst_busy", 32'(bus.busy_vec), 32'h0);
            chk("rst_stall", 32'(bus.stall), 32'h0);
            tick();
        end

        // Plain write then read
        wb(4'd5, 16'hA5A5);
        idle();
        bus.ra_addr = 4'd5; bus.rb_addr = 4'd5;
        @(negedge clk);
        chk("wr_ra", 32'(bus.ra_data), 32'hA5A5);
        chk("wr_rb", 32'(bus.rb_data), 32'hA5A5);
        chk("wr_busy", 32'(bus.busy_vec), 32'h0);
        tick();

        // RAW on R3
        issue_wr(4'd3);
        idle();
        bus.iss_en = 1'b1; bus.ra_en = 1'b1; bus.ra_addr = 4'd3;
        @(negedge clk);
        chk("raw_busy", 32'(bus.busy_vec), 32'h0008);
        chk("raw_stall", 32'(bus.stall), 32'h1);
        tick();
        @(negedge clk);
        chk("raw_hold", 32'(bus.stall), 32'h1);
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 16'h1234;
        @(negedge clk);
        chk("raw_wb_stall", 32'(bus.stall), BYP ? 32'h0 : 32'h1);
        chk("raw_wb_ra", 32'(bus.ra_data), BYP ? 32'h1234 : 32'h0);
        tick();
        bus.wb_en = 1'b0;
        @(negedge clk);
        chk("raw_after_stall", 32'(bus.stall), 32'h0);
        chk("raw_after_ra", 32'(bus.ra_data), 32'h1234);
        chk("raw_after_busy", 32'(bus.busy_vec), 32'h0);
        tick();

        // WAW on R7 and set/clear collision
        issue_wr(4'd7);
        idle();
        bus.iss_en = 1'b1; bus.iss_wr = 1'b1; bus.iss_addr = 4'd7;
        @(negedge clk);
        chk("waw_stall", 32'(bus.stall), 32'h1);
        chk("waw_busy", 32'(bus.busy_vec), 32'h0080);
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 16'h7777;
        @(negedge clk);
        chk("coll_stall", 32'(bus.stall), BYP ? 32'h0 : 32'h1);
        tick();
        idle();
        bus.ra_addr = 4'd7;
        @(negedge clk);
        chk("coll_busy", 32'(bus.busy_vec), BYP ? 32'h0080 : 32'h0);
        chk("coll_data", 32'(bus.ra_data), 32'h7777);
        tick();
        wb(4'd7, 16'h0707);
        idle();

        // Unused operand on a busy register
        issue_wr(4'd9);
        idle();
        bus.iss_en = 1'b1; bus.ra_addr = 4'd9;
        @(negedge clk);
        chk("unused_stall", 32'(bus.stall), 32'h0);
        tick();
        idle();
        bus.iss_en = 1'b1; bus.rb_en = 1'b1; bus.rb_addr = 4'd9;
        @(negedge clk);
        chk("unused_busy", 32'(bus.busy_vec), 32'h0200);
        chk("rb_raw_stall", 32'(bus.stall), 32'h1);
        tick();
        wb(4'd9, 16'h9999);

        // Reset mid-operation
        issue_wr(4'd2);
        issue_wr(4'd4);
        issue_wr(4'd15);
        idle();
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy_vec), 32'h8014);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 16'hBEEF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        bus.ra_addr = 4'd4;
        @(negedge clk);
        chk("mid_rst_busy", 32'(bus.busy_vec), 32'h0);
        chk("mid_rst_r4", 32'(bus.ra_data), 32'h0);
        tick();
        wb(4'd2, 16'h2222);
        idle();
        bus.ra_addr = 4'd2;
        @(negedge clk);
        chk("late_wb_r2", 32'(bus.ra_data), 32'h2222);
        chk("late_wb_busy", 32'(bus.busy_vec), 32'h0);
        tick();

        repeat (2) tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
